xbar_sched: RTL and testbench
=============================

# xbar_sched

Round-robin scheduler with starvation override for one side of the 4-port switch. It takes the per-port FIFO requests and their destination addresses, and masks out any requester whose destination FIFO is full. It issues a registered one-hot grant, then a decoded destination write strobe one cycle later. It replaces the bare arbiter plus write-enable decode inside the switch side, so the crossbar never writes into a full destination.

## Interface
Parameters:
- N, 4, number of requesting ports
- LOG_N, 2, width of grant index (clog2 N)
- AW_DEV, 2, destination address width
- N_DEV, 1<<AW_DEV, number of destination FIFOs
- MAX_WAIT, 7, starvation threshold in eligible-but-ungranted cycles
- WCW, 3, wait counter width; must hold MAX_WAIT

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- rqt_i  in  N  per-port request (FIFO non-empty)
- adr_i  in  N*AW_DEV  packed destinations; port i at [i*AW_DEV +: AW_DEV]
- full_i  in  N_DEV  destination FIFO full flags
- mask_i  in  N  static config; 1 disables port i
- gnt_o  out  N  one-hot grant, one cycle wide
- gnt_bin_o  out  LOG_N  binary index of the current grant
- gnt_vld_o  out  1  equals |gnt_o
- wen_o  out  N_DEV  one-hot destination write strobe
- starve_o  out  1  high in the cycle a grant was won by starvation override

## Operation
- Eligibility (combinational): elig[i] = rqt_i[i] & ~mask_i[i] & ~full_i[adr_i[i]].
- State machine:
  - States: IDLE, GNT, RECOV.
  - IDLE and RECOV: if |elig, go to GNT and register the winner; otherwise go to IDLE.
  - GNT: always go to RECOV.
- Winner selection:
  - If any port has wait[i]==MAX_WAIT and elig[i], the lowest such index wins and starve_o is set.
  - Otherwise, the first eligible port searching upward from ptr, wrapping mod N, wins.
- Round-robin pointer:
  - On every grant to port k, ptr <= (k+1) mod N, including override grants.
  - Wrap: a grant to port N-1 sets ptr=0.
- On entering GNT:
  - gnt_o <= onehot(k), gnt_bin_o <= k.
  - Latch adr_k into dst_q.
- On entering RECOV: wen_o <= onehot(dst_q). In every other cycle wen_o is 0.
- Wait counters (one WCW-bit counter per port), updated each cycle:
  - Cleared when the port is granted, or when elig[i]=0.
  - Otherwise incremented, saturating at MAX_WAIT.
  - In GNT state, eligible non-granted ports also increment.
- A grant is committed once registered. full_i or rqt_i changing during GNT does not cancel gnt_o or the following wen_o.
- The port just granted may be granted again from RECOV if it is still eligible. Round-robin order decides this.
- Reset values:
  - Outputs: gnt_o=0, gnt_bin_o=0, gnt_vld_o=0, wen_o=0, starve_o=0.
  - Internal: state=IDLE, ptr=0, dst_q=0, all wait counters 0.
- Reset mid-operation: rst_i high in any state forces all reset values at the next edge. A pending wen_o is dropped.

## Timing
- Latency:
  - Eligible at cycle t in IDLE → gnt_o high in cycle t+1.
  - wen_o high in cycle t+2.
- Throughput: at most one grant per 2 cycles. Back-to-back grants appear in cycles t+1, t+3, t+5…
- gnt_o, gnt_bin_o, gnt_vld_o and starve_o are valid together for exactly one cycle.
- wen_o is always exactly one cycle after its gnt_o and is never concurrent with it.
- full_i is sampled only in the cycle of the decision (IDLE/RECOV). Upstream guarantees the full flag reflects the write pending in that same cycle.
- With no eligible requests, outputs stay 0 and the state stays IDLE.

## Test plan
- Single request: rqt_i=4'b0100, adr_i port2=3, full_i=0.
  - Required: gnt_o=4'b0100 and gnt_bin_o=2 one cycle later; wen_o=4'b1000 the cycle after that.
  - Afterwards ptr=3.
- All four requesting continuously with distinct non-full destinations.
  - Required: grant order 0,1,2,3,0 in cycles 1,3,5,7,9; no wen_o coincides with gnt_o.
- Full masking: rqt_i=4'b0011, port0→dest1 with full_i=4'b0010, port1→dest0.
  - Required: only port1 granted while full_i[1]=1.
  - Clearing full_i[1] → port0 granted at the next decision.
- Starvation: MAX_WAIT=7; port3 eligible throughout, with ptr manipulated via mask_i toggling so ports 0-2 keep winning.
  - Required: port3's counter reaches 7, then port3 is granted with starve_o=1 and its counter is cleared.
- Commit and wrap: full_i[dest] rises in the GNT cycle.
  - Required: wen_o still asserted for that destination.
  - A grant to port 3 wraps ptr to 0.
- Reset mid-op: assert rst_i during the GNT cycle.
  - Required: the next cycle has wen_o=0 and all outputs 0.
  - After release with rqt_i=4'b1111, port0 is granted first.

Source files
------------

// File: rtl/xbar_sched_if.sv
// xbar_sched_if: request/grant bundle between one switch side and its scheduler.
//
// Signals (names carry the scheduler's point of view):
//   rqt_i     [N]          per-port request (source FIFO non-empty)
//   adr_i     [N*AW_DEV]   packed destinations, port i at [i*AW_DEV +: AW_DEV]
//   full_i    [N_DEV]      destination FIFO full flags
//   mask_i    [N]          static config, 1 disables a port
//   gnt_o     [N]          one-hot grant, one cycle wide
//   gnt_bin_o [LOG_N]      binary index of the current grant
//   gnt_vld_o              |gnt_o
//   wen_o     [N_DEV]      one-hot destination write strobe
//   starve_o               grant was won by starvation override
//
// Handshake: a port holds rqt_i while it has data. A grant is a one-cycle
// pulse on gnt_o and is committed once it appears; the matching wen_o pulse
// follows exactly one cycle later and is never cancelled by later changes
// on rqt_i or full_i. There is no back-pressure on gnt_o or wen_o.
//
// Modports: master = switch side driving requests, slave = the scheduler.
interface xbar_sched_if #(
  parameter int N      = 4,
  parameter int LOG_N  = 2,
  parameter int AW_DEV = 2,
  parameter int N_DEV  = 1 << AW_DEV
);
  logic [N-1:0]        rqt_i;
  logic [N*AW_DEV-1:0] adr_i;
  logic [N_DEV-1:0]    full_i;
  logic [N-1:0]        mask_i;
  logic [N-1:0]        gnt_o;
  logic [LOG_N-1:0]    gnt_bin_o;
  logic                gnt_vld_o;
  logic [N_DEV-1:0]    wen_o;
  logic                starve_o;

  modport master (
    output rqt_i, adr_i, full_i, mask_i,
    input  gnt_o, gnt_bin_o, gnt_vld_o, wen_o, starve_o
  );

  modport slave (
    input  rqt_i, adr_i, full_i, mask_i,
    output gnt_o, gnt_bin_o, gnt_vld_o, wen_o, starve_o
  );
endinterface

// File: rtl/xbar_sched.sv
// xbar_sched: round-robin scheduler with starvation override for one side of
// the 4-port switch. Requesters whose destination FIFO is full are masked
// out, a registered one-hot grant is issued, and the decoded destination
// write strobe follows one cycle later.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   bus          xbar_sched_if.slave (requests in, grant/strobe out)
//   dbg_state_o  current FSM state (IDLE=0, GNT=1, RECOV=2)
module xbar_sched #(
  parameter int N        = 4,
  parameter int LOG_N    = 2,
  parameter int AW_DEV   = 2,
  parameter int N_DEV    = 1 << AW_DEV,
  parameter int MAX_WAIT = 7,
  parameter int WCW      = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  xbar_sched_if.slave  bus,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT = 2'd1, RECOV = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LOG_N-1:0]  ptr_q, ptr_d;
  logic [LOG_N-1:0]  gnt_bin_q, gnt_bin_d;
  logic [AW_DEV-1:0] dst_q, dst_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [N_DEV-1:0]  wen_q, wen_d;
  logic              starve_q, starve_d;
  logic [WCW-1:0]    wait_q [N];
  logic [WCW-1:0]    wait_d [N];

  logic [N-1:0]      elig;
  logic [LOG_N-1:0]  win;
  logic [LOG_N-1:0]  cand;
  logic              win_starve;
  logic              found;
  logic              decide;

  // A port is eligible only if its destination FIFO can take the write.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++) begin
      elig[i] = bus.rqt_i[i] & ~bus.mask_i[i]
              & ~bus.full_i[bus.adr_i[i*AW_DEV +: AW_DEV]];
    end
  end

  // Winner: lowest-index starved port first, else round-robin from ptr_q.
  always_comb begin
    win        = '0;
    cand       = '0;
    win_starve = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_starve && elig[i] && (wait_q[i] == WCW'(MAX_WAIT))) begin
        win_starve = 1'b1;
        win        = LOG_N'(i);
      end
    end
    if (!win_starve) begin
      for (int off = 0; off < N; off++) begin
        cand = LOG_N'((int'(ptr_q) + off) % N);
        if (!found && elig[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  // Decisions happen only in IDLE/RECOV, which caps grants at one per 2 cycles.
  assign decide = (state_q != GNT) && (|elig);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    dst_d     = dst_q;
    gnt_d     = '0;
    gnt_bin_d = '0;
    starve_d  = 1'b0;
    wen_d     = '0;
    case (state_q)
      GNT: begin
        // Committed grant: strobe the latched destination regardless of full_i.
        state_d = RECOV;
        wen_d   = N_DEV'(1) << dst_q;
      end
      default: begin
        if (decide) begin
          state_d   = GNT;
          gnt_d     = N'(1) << win;
          gnt_bin_d = win;
          starve_d  = win_starve;
          dst_d     = bus.adr_i[win*AW_DEV +: AW_DEV];
          ptr_d     = (win == LOG_N'(N - 1)) ? '0 : win + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Wait counters: cleared on winning a decision or when ineligible,
  // otherwise count every cycle (GNT cycles included), saturating.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wait_d[i] = wait_q[i];
      if ((decide && (win == LOG_N'(i))) || !elig[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WCW'(MAX_WAIT)) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      dst_q     <= '0;
      gnt_q     <= '0;
      gnt_bin_q <= '0;
      starve_q  <= 1'b0;
      wen_q     <= '0;
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      dst_q     <= dst_d;
      gnt_q     <= gnt_d;
      gnt_bin_q <= gnt_bin_d;
      starve_q  <= starve_d;
      wen_q     <= wen_d;
      for (int i = 0; i < N; i++) wait_q[i] <= wait_d[i];
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_bin_o = gnt_bin_q;
  assign bus.gnt_vld_o = |gnt_q;
  assign bus.wen_o     = wen_q;
  assign bus.starve_o  = starve_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_xbar_sched.sv
// tb_xbar_sched: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the scheduler.
module tb_xbar_sched;

  localparam int N = 4;
  localparam int MAX_WAIT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  xbar_sched_if bus ();

  xbar_sched dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model state: which port (if any) is showing a grant, which destination
  // gets written next cycle, the rotation pointer and per-port wait counts.
  int m_gnt_idx = -1;
  int m_gnt_dst = 0;
  int m_wen_dst = -1;
  bit m_starve  = 1'b0;
  int m_ptr     = 0;
  int m_wait [N];

  function automatic int dst_of(int p);
    logic [1:0] a;
    a = bus.adr_i[p*2 +: 2];
    return int'(a);
  endfunction

  always @(posedge clk) begin
    bit elig [N];
    bit any;
    int k;
    bit st;
    if (rst) begin
      m_gnt_idx = -1; m_gnt_dst = 0; m_wen_dst = -1; m_starve = 1'b0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
    end else begin
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        elig[i] = bus.rqt_i[i] && !bus.mask_i[i] && !bus.full_i[dst_of(i)];
        any = any || elig[i];
      end
      k = -1; st = 1'b0;
      // A new decision is only possible when no grant is on display.
      if (m_gnt_idx < 0 && any) begin
        for (int i = 0; i < N; i++)
          if (k < 0 && elig[i] && m_wait[i] == MAX_WAIT) begin k = i; st = 1'b1; end
        for (int off = 0; off < N; off++)
          if (k < 0 && elig[(m_ptr + off) % N]) k = (m_ptr + off) % N;
      end
      m_wen_dst = (m_gnt_idx >= 0) ? m_gnt_dst : -1;
      for (int i = 0; i < N; i++) begin
        if (i == k || !elig[i]) m_wait[i] = 0;
        else if (m_wait[i] < MAX_WAIT) m_wait[i] = m_wait[i] + 1;
      end
      if (k >= 0) begin
        m_ptr = (k + 1) % N;
        m_gnt_dst = dst_of(k);
      end
      m_gnt_idx = k;
      m_starve  = st;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] e_gnt, e_wen;
    logic [1:0] e_bin;
    e_gnt = (m_gnt_idx >= 0) ? 4'(1 << m_gnt_idx) : 4'd0;
    e_bin = (m_gnt_idx >= 0) ? 2'(m_gnt_idx) : 2'd0;
    e_wen = (m_wen_dst >= 0) ? 4'(1 << m_wen_dst) : 4'd0;
    vectors++;
    if (bus.gnt_o !== e_gnt || bus.gnt_bin_o !== e_bin || bus.gnt_vld_o !== (m_gnt_idx >= 0)
        || bus.wen_o !== e_wen || bus.starve_o !== m_starve) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t: got gnt=%b bin=%0d vld=%b wen=%b starve=%b, want gnt=%b bin=%0d vld=%b wen=%b starve=%b",
               $time, bus.gnt_o, bus.gnt_bin_o, bus.gnt_vld_o, bus.wen_o, bus.starve_o,
               e_gnt, e_bin, (m_gnt_idx >= 0), e_wen, m_starve);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rqt, input logic [7:0] adr,
                       input logic [3:0] full, input logic [3:0] mask);
    bus.rqt_i = rqt; bus.adr_i = adr; bus.full_i = full; bus.mask_i = mask;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 8'b0, 4'b0, 4'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(4'b0, 8'b0, 4'b0, 4'b0);
    tick();
    // Reset state
    check("reset_gnt", int'(bus.gnt_o), 0);
    check("reset_wen", int'(bus.wen_o), 0);
    check("reset_vld", int'(bus.gnt_vld_o), 0);
    do_reset();

    // Single request: port2 -> dest3
    drive(4'b0100, 8'b0011_0000, 4'b0, 4'b0);
    tick();
    check("single_gnt", int'(bus.gnt_o), 4'b0100);
    check("single_bin", int'(bus.gnt_bin_o), 2);
    drive(4'b0, 8'b0011_0000, 4'b0, 4'b0);
    tick();
    check("single_wen", int'(bus.wen_o), 4'b1000);
    check("single_gnt_off", int'(bus.gnt_o), 0);
    check("single_ptr_model", m_ptr, 3);

    // All four requesting, distinct destinations
    do_reset();
    drive(4'b1111, 8'b11_10_01_00, 4'b0, 4'b0);
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("rr_no_overlap", int'((|bus.gnt_o) && (|bus.wen_o)), 0);
      if (j % 2 == 1) check("rr_order", int'(bus.gnt_bin_o), ((j - 1) / 2) % N);
      if (j == 7) check("rr_starve_p3", int'(bus.starve_o), 0);
      if (j == 9) check("rr_starve_p0", int'(bus.starve_o), 1);
    end

    // Full masking: port0 -> dest1 (full), port1 -> dest0
    do_reset();
    drive(4'b0011, 8'b00_00_00_01, 4'b0010, 4'b0);
    tick(); check("full_gnt1", int'(bus.gnt_o), 4'b0010);
    tick(); check("full_wen1", int'(bus.wen_o), 4'b0001);
    tick(); check("full_gnt2", int'(bus.gnt_o), 4'b0010);
    bus.full_i = 4'b0000;
    tick(); tick();
    check("full_clear_gnt", int'(bus.gnt_o), 4'b0001);

    // Starvation: port3 wins once, then keeps requesting while 0..2 win
    do_reset();
    drive(4'b1000, 8'b11_10_01_00, 4'b0, 4'b0);
    tick();
    check("starve_first", int'(bus.gnt_o), 4'b1000);
    bus.rqt_i = 4'b1111;
    for (int j = 2; j <= 9; j++) begin
      tick();
      if (j == 8) check("starve_wait_model", m_wait[3], 7);
    end
    check("starve_gnt", int'(bus.gnt_o), 4'b1000);
    check("starve_flag", int'(bus.starve_o), 1);
    check("starve_clear_model", m_wait[3], 0);

    // Commit: full rises during GNT, strobe still issued; then wrap via port3
    do_reset();
    drive(4'b0001, 8'b00_00_00_10, 4'b0, 4'b0);
    tick(); check("commit_gnt", int'(bus.gnt_o), 4'b0001);
    drive(4'b0, 8'b00_00_00_10, 4'b0100, 4'b0);
    tick(); check("commit_wen", int'(bus.wen_o), 4'b0100);
    drive(4'b1000, 8'b01_00_00_10, 4'b0100, 4'b0);
    tick(); check("wrap_gnt", int'(bus.gnt_bin_o), 3);
    check("wrap_ptr_model", m_ptr, 0);
    bus.rqt_i = 4'b0;
    tick();

    // Reset during GNT drops the pending strobe
    do_reset();
    drive(4'b0001, 8'b0, 4'b0, 4'b0);
    tick(); check("rst_mid_gnt", int'(bus.gnt_o), 4'b0001);
    rst = 1'b1;
    tick();
    check("rst_mid_wen", int'(bus.wen_o), 0);
    check("rst_mid_gnt_off", int'(bus.gnt_o), 0);
    rst = 1'b0;
    drive(4'b1111, 8'b11_10_01_00, 4'b0, 4'b0);
    tick(); check("rst_after_gnt", int'(bus.gnt_o), 4'b0001);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] r, f;
      for (int b = 0; b < 4; b++) begin
        r[b] = ($urandom_range(3, 0) != 0);
        f[b] = ($urandom_range(7, 0) == 0);
      end
      bus.rqt_i  = r;
      bus.full_i = f;
      bus.adr_i  = 8'($urandom);
      if (c % 64 == 0) bus.mask_i = ($urandom_range(2, 0) == 0) ? 4'($urandom) : 4'b0;
      rst = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
